// File: rtl/trellis_bert_pkg.sv
// Shared constants and types for the trellis-decoder PN15 bit-error-rate tester.
// Holds the PN15 order, its feedback taps and the sync state machine encoding.
package trellis_bert_pkg;

  localparam int PN_ORDER = 15;
  localparam int TAP_A    = 14;
  localparam int TAP_B    = 13;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } bertState_t;

  function automatic logic [31:0] satInc32(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (&value) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/trellis_bert_pn_predictor.sv
// PN15 shift register that predicts the next bit of the reference sequence.
// fillZero flags that the register would be all zeros after the pending load.
module pn_predictor
  import trellis_bert_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic loadBit,
  output logic predicted,
  output logic fillZero
);

  logic [PN_ORDER-1:0] sr;

  assign predicted = sr[TAP_A] ^ sr[TAP_B];
  assign fillZero  = ({sr[PN_ORDER-2:0], loadBit} == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= {sr[PN_ORDER-2:0], loadBit};
    end
  end

endmodule

// File: rtl/trellis_bert.sv
// PN15 BERT behind a trellis decoder: acquires sync, then flywheels the reference
// and counts bit errors, dropping lock when a window collects too many errors.
module trellis_bert
  import trellis_bert_pkg::*;
#(
  parameter int WINDOW_LOG2 = 10,
  parameter int SYNC_THRESH = 32,
  parameter int LOSS_THRESH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bitEn,
  input  logic        bitIn,
  input  logic        clearCounts,
  output logic        locked,
  output logic [31:0] bitCount,
  output logic [31:0] errorCount,
  output logic [15:0] windowErrors,
  output logic        errorStrobe
);

  localparam int MATCH_W = $clog2(SYNC_THRESH + 1);

  bertState_t               state;
  logic [3:0]               fillCnt;
  logic [MATCH_W-1:0]       matchCnt;
  logic [WINDOW_LOG2-1:0]   winCnt;

  logic predBit;
  logic fillZero;
  logic isMatch;
  logic shiftBit;
  logic winWrap;
  logic lossHit;
  logic [16:0] winErrTotal;

  // Once locked the register flywheels on its own prediction so data errors cannot corrupt it.
  assign shiftBit = (state == LOCKED) ? predBit : bitIn;
  assign isMatch  = (bitIn == predBit);
  assign winWrap  = &winCnt;

  assign winErrTotal = {1'b0, windowErrors} + {16'd0, ~isMatch};
  assign lossHit     = !clearCounts && (winErrTotal >= 17'(LOSS_THRESH));

  assign locked = (state == LOCKED);

  pn_predictor uPredictor (
    .clk       (clk),
    .reset     (reset),
    .load      (bitEn),
    .loadBit   (shiftBit),
    .predicted (predBit),
    .fillZero  (fillZero)
  );

  // Sync state machine plus error accounting; a clear pulse overrides counting of the same bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      fillCnt      <= '0;
      matchCnt     <= '0;
      winCnt       <= '0;
      bitCount     <= '0;
      errorCount   <= '0;
      windowErrors <= '0;
      errorStrobe  <= 1'b0;
    end else begin
      errorStrobe <= 1'b0;
      if (clearCounts) begin
        bitCount     <= '0;
        errorCount   <= '0;
        windowErrors <= '0;
      end
      if (bitEn) begin
        case (state)
          HUNT: begin
            if (fillCnt == 4'(PN_ORDER - 1)) begin
              fillCnt <= '0;
              if (!fillZero) begin
                state    <= VERIFY;
                matchCnt <= '0;
              end
            end else begin
              fillCnt <= fillCnt + 4'd1;
            end
          end
          VERIFY: begin
            if (isMatch) begin
              if (matchCnt == MATCH_W'(SYNC_THRESH - 1)) begin
                state    <= LOCKED;
                matchCnt <= '0;
              end else begin
                matchCnt <= matchCnt + 1'b1;
              end
            end else begin
              state    <= HUNT;
              fillCnt  <= '0;
              matchCnt <= '0;
            end
          end
          LOCKED: begin
            winCnt <= winCnt + 1'b1;
            if (!clearCounts) begin
              bitCount <= satInc32(bitCount);
              if (!isMatch) begin
                errorCount  <= satInc32(errorCount);
                errorStrobe <= 1'b1;
              end
              if (winWrap) begin
                windowErrors <= '0;
              end else if (!isMatch) begin
                windowErrors <= satInc16(windowErrors);
              end
            end
            if (winWrap && lossHit) begin
              state    <= HUNT;
              fillCnt  <= '0;
              matchCnt <= '0;
            end
          end
          default: begin
            state    <= HUNT;
            fillCnt  <= '0;
            matchCnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trellis_bert.sv
// Directed bench for trellis_bert: PN15 lock, error counting, clear, loss of lock,
// asynchronous reset and all-zero rejection, checked against hand-computed values.
module tb_trellis_bert;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bitEn = 1'b0;
  logic        bitIn = 1'b0;
  logic        clearCounts = 1'b0;
  logic        locked;
  logic [31:0] bitCount;
  logic [31:0] errorCount;
  logic [15:0] windowErrors;
  logic        errorStrobe;

  int          assertCount = 0;
  int          failCount = 0;
  int          strobeCount = 0;
  logic [14:0] genSr = 15'h7FFF;

  trellis_bert dut (
    .clk          (clk),
    .reset        (reset),
    .bitEn        (bitEn),
    .bitIn        (bitIn),
    .clearCounts  (clearCounts),
    .locked       (locked),
    .bitCount     (bitCount),
    .errorCount   (errorCount),
    .windowErrors (windowErrors),
    .errorStrobe  (errorStrobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (errorStrobe) strobeCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One strobed bit; returns 1 time unit after a rising edge with outputs settled.
  task automatic applyStimulus(input logic b, input logic clr, input int gap);
    bitIn = b;
    bitEn = 1'b1;
    clearCounts = clr;
    @(posedge clk);
    #1;
    bitEn = 1'b0;
    clearCounts = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendPn(input int n, input int gap, input logic invert);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = genSr[14] ^ genSr[13];
      genSr = {genSr[13:0], b};
      applyStimulus(b ^ invert, 1'b0, gap);
    end
  endtask

  initial begin
    logic b;
    $display("[TB] trellis_bert directed test start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset locked", 32'(locked), 32'd0);
    checkOutput("reset bitCount", bitCount, 32'd0);
    checkOutput("reset errorCount", errorCount, 32'd0);
    checkOutput("reset windowErrors", 32'(windowErrors), 32'd0);
    checkOutput("reset errorStrobe", 32'(errorStrobe), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Acquisition at one bit every 5 clocks: 15 fill + 32 verify bits.
    sendPn(46, 4, 1'b0);
    checkOutput("not locked after 46", 32'(locked), 32'd0);
    sendPn(1, 4, 1'b0);
    checkOutput("locked after 47", 32'(locked), 32'd1);
    checkOutput("bitCount at lock", bitCount, 32'd0);
    sendPn(20, 4, 1'b0);
    checkOutput("bitCount 20 after lock", bitCount, 32'd20);
    checkOutput("errorCount clean", errorCount, 32'd0);

    // Clear without a bit strobe, then one inverted bit every 100 for 10000 bits.
    clearCounts = 1'b1;
    @(posedge clk);
    #1;
    clearCounts = 1'b0;
    checkOutput("clear bitCount", bitCount, 32'd0);
    strobeCount = 0;
    for (int i = 0; i < 10000; i++) begin
      sendPn(1, 1, (i % 100) == 99);
    end
    checkOutput("sparse errorCount", errorCount, 32'd100);
    checkOutput("sparse bitCount", bitCount, 32'd10000);
    checkOutput("sparse strobes", 32'(strobeCount), 32'd100);
    checkOutput("sparse locked", 32'(locked), 32'd1);
    checkOutput("sparse windowErrors", 32'(windowErrors), 32'd9);

    // Single error: strobe lasts exactly one cycle.
    sendPn(1, 0, 1'b1);
    checkOutput("strobe high", 32'(errorStrobe), 32'd1);
    checkOutput("errorCount 101", errorCount, 32'd101);
    @(posedge clk);
    #1;
    checkOutput("strobe low next", 32'(errorStrobe), 32'd0);

    // Clear coincident with an error bit: clear wins and the error is dropped.
    b = genSr[14] ^ genSr[13];
    genSr = {genSr[13:0], b};
    applyStimulus(~b, 1'b1, 0);
    checkOutput("clear+err errorCount", errorCount, 32'd0);
    checkOutput("clear+err bitCount", bitCount, 32'd0);
    checkOutput("clear+err strobe", 32'(errorStrobe), 32'd0);
    checkOutput("clear+err windowErrors", 32'(windowErrors), 32'd0);
    sendPn(10, 1, 1'b0);
    checkOutput("post-clear bitCount", bitCount, 32'd10);
    checkOutput("post-clear errorCount", errorCount, 32'd0);

    // Inverted data: window wraps 208 bits later with 208 errors and drops lock.
    sendPn(207, 1, 1'b1);
    checkOutput("still locked before wrap", 32'(locked), 32'd1);
    checkOutput("errors before wrap", 32'(windowErrors), 32'd207);
    sendPn(1, 1, 1'b1);
    checkOutput("unlocked at wrap", 32'(locked), 32'd0);
    checkOutput("errorCount at wrap", errorCount, 32'd208);
    checkOutput("bitCount at wrap", bitCount, 32'd218);
    checkOutput("windowErrors at wrap", 32'(windowErrors), 32'd0);
    sendPn(816, 1, 1'b1);
    checkOutput("unlocked on inverted", 32'(locked), 32'd0);
    checkOutput("no count when unlocked", errorCount, 32'd208);
    sendPn(46, 1, 1'b0);
    checkOutput("relock not early", 32'(locked), 32'd0);
    sendPn(1, 1, 1'b0);
    checkOutput("relock at 47", 32'(locked), 32'd1);

    // Asynchronous reset mid-lock, right after an error bit.
    sendPn(4, 1, 1'b0);
    sendPn(1, 0, 1'b1);
    checkOutput("pre-reset strobe", 32'(errorStrobe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async locked", 32'(locked), 32'd0);
    checkOutput("async bitCount", bitCount, 32'd0);
    checkOutput("async errorCount", errorCount, 32'd0);
    checkOutput("async windowErrors", 32'(windowErrors), 32'd0);
    checkOutput("async strobe", 32'(errorStrobe), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    sendPn(47, 1, 1'b0);
    checkOutput("relock after reset", 32'(locked), 32'd1);
    checkOutput("bitCount after reset", bitCount, 32'd0);
    sendPn(3, 1, 1'b0);
    checkOutput("counts restart", bitCount, 32'd3);

    // All-zero input never satisfies the fill check.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      applyStimulus(1'b0, 1'b0, 1);
    end
    checkOutput("zeros locked", 32'(locked), 32'd0);
    checkOutput("zeros bitCount", bitCount, 32'd0);
    checkOutput("zeros errorCount", errorCount, 32'd0);
    checkOutput("zeros windowErrors", 32'(windowErrors), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/trellis_bert.md
TRELLIS_BERT -- requirements
Module: trellis_bert

Interface
REQ-001 Parameter WINDOW_LOG2, default 10: loss-of-lock window length, 2^WINDOW_LOG2 bits.
REQ-002 Parameter SYNC_THRESH, default 32: consecutive matching bits in VERIFY required to declare lock.
REQ-003 Parameter LOSS_THRESH, default 64: errors within one window that force return to HUNT.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 bitEn  input  1  one-cycle strobe qualifying bitIn; this is the trellis decoder's symEnOut.
REQ-007 bitIn  input  1  decoded bit; this is the trellis decoder's decision output.
REQ-008 clearCounts  input  1  one-cycle pulse that zeroes bitCount, errorCount and windowErrors.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 bitCount  output  32  bits compared while locked; saturating.
REQ-011 errorCount  output  32  bit errors while locked; saturating.
REQ-012 windowErrors  output  16  errors in the current window; saturating.
REQ-013 errorStrobe  output  1  one-cycle pulse for each counted error.

Function
REQ-014 Reference sequence SHALL be PN15: x^15+x^14+1, with predicted bit = sr[14] XOR sr[13].
REQ-015 FSM states SHALL be HUNT, VERIFY and LOCKED; all transitions occur only on cycles with bitEn high.
REQ-016 HUNT: shift bitIn into sr and increment fillCnt; when fillCnt reaches 15, go to VERIFY, unless sr == 0, in which case fillCnt resets and the FSM stays in HUNT.
REQ-017 VERIFY: compare bitIn with the predicted bit and shift bitIn into sr.
REQ-018 VERIFY on match: increment matchCnt; when matchCnt reaches SYNC_THRESH, go to LOCKED.
REQ-019 VERIFY on mismatch: go to HUNT and zero fillCnt and matchCnt.
REQ-020 LOCKED: sr SHALL flywheel, shifting in the predicted bit rather than bitIn.
REQ-021 LOCKED: every bitEn increments bitCount; every mismatch increments errorCount and windowErrors and pulses errorStrobe.
REQ-022 LOCKED: winCnt counts bits modulo 2^WINDOW_LOG2. On wrap, if windowErrors (including the current bit) >= LOSS_THRESH, go to HUNT; otherwise stay LOCKED. windowErrors zeroes on every wrap.
REQ-023 Outputs SHALL update on the clock edge following the bitEn cycle (latency of 1 clk); errorStrobe is never high for more than 1 cycle.
REQ-024 Counters SHALL saturate at all-ones and never wrap.
REQ-025 clearCounts together with bitEn: clear wins, and that bit is not counted; FSM state, sr and winCnt are unaffected by clearCounts.
REQ-026 bitEn low: no state or counter change; errorStrobe low.
REQ-027 Errors outside LOCKED SHALL NOT be counted.

Reset
REQ-028 Asserting reset SHALL force, at any time including mid-operation: state HUNT; sr, fillCnt, matchCnt, winCnt all 0; locked 0; bitCount, errorCount, windowErrors all 0; errorStrobe 0.
REQ-029 Counters restart from 0 after reset release; no clearCounts pulse is required.

Structure
REQ-030 Package trellis_bert_pkg SHALL hold PN_ORDER=15, the tap positions (14, 13) and the state enum typedef.
REQ-031 The sequence generator SHALL be a sub-module pn_predictor: holds sr; inputs load and loadBit; output predicted bit.
REQ-032 Target implementation size: 120-400 lines of RTL.

Verification
REQ-033 Error-free PN15 seeded 0x7FFF at one bitEn per 5 clks -> locked high after 15+32 bits; errorCount 0; bitCount equals bits sent after lock.
REQ-034 Locked stream with one bit inverted every 100 bits for 10,000 bits -> errorCount 100 (±1); errorStrobe pulses 100 times; locked stays high.
REQ-035 All-zeros input for 500 bits -> stays HUNT; locked 0; all counters 0.
REQ-036 Locked, then inverted data for 1024 bits -> return to HUNT at the first window wrap with >= 64 errors; relock within 47 bits of clean PN15 resuming.
REQ-037 clearCounts coincident with an error bitEn -> counters read 0 next cycle; that error is not counted.
REQ-038 Reset asserted mid-LOCKED, asynchronously between clk edges -> all outputs 0 immediately; relock within 47 bits after release.
